// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences one weight load into the weight memory.
// A start pulse resets the 64-to-16 unpacker for one cycle (CLEAR), then LOAD
// lets exactly ceil(NUM_WEIGHTS/4) FIFO words through to the unpacker and
// commits the first NUM_WEIGHTS weight writes, checking that every committed
// write lands at the expected sequential address. FLUSH drains the rest of the
// unpacker group before the block settles in DONE or ERROR.
//
// Strobe semantics: a FIFO word is consumed only in a cycle where
// unp_fifo_rd_en=1 and unp_empty=0; a weight is committed only in a cycle where
// mem_wr_en=1. Neither side stalls the other, so there is no ready path.
module weight_load_ctrl #(
  parameter int NUM_WEIGHTS    = 76323,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        fifo_empty,
  input  logic        unp_fifo_rd_en,
  input  logic        unp_wr_en,
  input  logic [31:0] unp_wr_addr,
  output logic        unp_empty,
  output logic        unp_rst_n,
  output logic        mem_wr_en,
  output logic [31:0] weight_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        infer_en,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] NUM_W        = 32'(NUM_WEIGHTS);
  localparam logic [31:0] LAST_W       = 32'(NUM_WEIGHTS - 1);
  localparam logic [31:0] WORDS_NEEDED = 32'((NUM_WEIGHTS + 3) / 4);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] weight_count_q;
  logic [31:0] word_cnt_q;
  logic [31:0] timeout_q;
  logic        abort_flag_q;
  logic        busy_q, done_q, error_q, unp_rst_n_q;

  logic        in_write_state;
  logic        word_pop;
  logic        addr_bad;
  logic        final_wr;
  logic        abort_set;
  logic        clear_now;

  // Gating of the unpacker's view of the FIFO and of the memory write strobe.
  always_comb begin
    in_write_state = (state_q == S_LOAD) || (state_q == S_FLUSH);
    unp_empty      = fifo_empty || (state_q != S_LOAD) || (word_cnt_q >= WORDS_NEEDED);
    mem_wr_en      = unp_wr_en && in_write_state && (weight_count_q < NUM_W);
    word_pop       = unp_fifo_rd_en && !unp_empty;
    addr_bad       = mem_wr_en && (unp_wr_addr != weight_count_q);
    final_wr       = mem_wr_en && (weight_count_q == LAST_W);
    // CLEAR is one cycle long and only entered from outside it, so a CLEAR
    // next-state always marks the entry edge.
    clear_now      = (state_d == S_CLEAR);
  end

  // Next-state decode; a bad address beats completion, completion beats abort.
  always_comb begin
    state_d   = state_q;
    abort_set = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (addr_bad) begin
          state_d = S_ERROR;
        end else if (final_wr) begin
          state_d = S_FLUSH;
        end else if (abort) begin
          state_d   = S_FLUSH;
          abort_set = 1'b1;
        end else if (!unp_wr_en && (timeout_q >= TIMEOUT_LAST)) begin
          state_d = S_ERROR;
        end
      end
      S_FLUSH: begin
        if (addr_bad) begin
          state_d = S_ERROR;
        end else if (!unp_wr_en) begin
          state_d = (!abort_flag_q && (weight_count_q == NUM_W)) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered status decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      weight_count_q <= '0;
      word_cnt_q     <= '0;
      timeout_q      <= '0;
      abort_flag_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      unp_rst_n_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (clear_now)      weight_count_q <= '0;
      else if (mem_wr_en) weight_count_q <= weight_count_q + 32'd1;

      if (clear_now)     word_cnt_q <= '0;
      else if (word_pop) word_cnt_q <= word_cnt_q + 32'd1;

      // Idle-cycle counter only runs in LOAD; any unpacker write restarts it.
      if (clear_now || (state_q != S_LOAD) || unp_wr_en) timeout_q <= '0;
      else                                               timeout_q <= timeout_q + 32'd1;

      if (clear_now)      abort_flag_q <= 1'b0;
      else if (abort_set) abort_flag_q <= 1'b1;

      busy_q      <= (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_FLUSH);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
      unp_rst_n_q <= (state_d != S_CLEAR);
    end
  end

  assign weight_count = weight_count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign infer_en     = done_q;
  assign error        = error_q;
  assign unp_rst_n    = unp_rst_n_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl with NUM_WEIGHTS=10, TIMEOUT_CYCLES=16.
// A small unpacker model pops a FIFO word, then issues four sequential writes.
module tb_weight_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        fifo_empty;
  logic        unp_fifo_rd_en;
  logic        unp_wr_en;
  logic [31:0] unp_wr_addr;
  logic        unp_empty;
  logic        unp_rst_n;
  logic        mem_wr_en;
  logic [31:0] weight_count;
  logic        busy, done, error, infer_en;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  weight_load_ctrl #(.NUM_WEIGHTS(10), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fifo_empty(fifo_empty), .unp_fifo_rd_en(unp_fifo_rd_en),
    .unp_wr_en(unp_wr_en), .unp_wr_addr(unp_wr_addr),
    .unp_empty(unp_empty), .unp_rst_n(unp_rst_n), .mem_wr_en(mem_wr_en),
    .weight_count(weight_count), .busy(busy), .done(done), .error(error),
    .infer_en(infer_en), .dbg_state(dbg_state)
  );

  // Clock / reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Unpacker model; runs from LOAD until busy drops or the budget expires.
  // abort_at: raise abort for one cycle once that many weights were committed.
  // bad_idx : write with that index carries address bad_idx+1.
  task automatic drive_load(input int fifo_words, input int abort_at, input int bad_idx,
                            output int pops, output int mem_writes, output int addr_err,
                            output int gate_viol, output int fifo_left, output int expired);
    int fifo_cnt, group, addr;
    bit aborted, pop_now;
    fifo_cnt = fifo_words; group = 0; addr = 0; aborted = 0;
    pops = 0; mem_writes = 0; addr_err = 0; gate_viol = 0; expired = 1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      fifo_empty     = (fifo_cnt == 0);
      unp_fifo_rd_en = 1'b0;
      unp_wr_en      = 1'b0;
      unp_wr_addr    = '0;
      abort          = 1'b0;
      if (group > 0) begin
        unp_wr_en   = 1'b1;
        unp_wr_addr = (addr == bad_idx) ? 32'(addr + 1) : 32'(addr);
      end else if (fifo_cnt > 0) begin
        unp_fifo_rd_en = 1'b1;
      end
      if (abort_at >= 0 && mem_writes == abort_at && !aborted) begin
        abort = 1'b1;
        aborted = 1;
      end
      #1;
      pop_now = unp_fifo_rd_en && !unp_empty;
      if (mem_wr_en) begin
        if (addr != bad_idx && unp_wr_addr != 32'(mem_writes)) addr_err++;
        mem_writes++;
      end
      if (pops >= 3 && dbg_state == 3'd2 && fifo_cnt > 0 && unp_empty !== 1'b1) gate_viol++;
      tick();
      if (pop_now) begin
        fifo_cnt--; pops++; group = 4;
      end else if (group > 0) begin
        group--; addr++;
      end
      if (busy !== 1'b1) begin
        expired = 0;
        break;
      end
    end
    fifo_left = fifo_cnt;
    fifo_empty = 1'b1; unp_fifo_rd_en = 1'b0; unp_wr_en = 1'b0; unp_wr_addr = '0; abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
    unp_fifo_rd_en = 1'b1; unp_wr_en = 1'b1; unp_wr_addr = '0;
    #3;
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++; if (unp_rst_n !== 1'b0) begin failures++; $display("FAIL reset_unp_rst_n: got %b expected 0", unp_rst_n); end
    checks++; if (unp_empty !== 1'b1) begin failures++; $display("FAIL reset_unp_empty: got %b expected 1", unp_empty); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_mem_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if ({busy, done, error, infer_en} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, infer_en}); end
    checks++; if (weight_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", weight_count); end
    unp_fifo_rd_en = 1'b0; unp_wr_en = 1'b0; fifo_empty = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL post_reset_idle: got %0d expected 0", dbg_state); end
    checks++; if (unp_rst_n !== 1'b1) begin failures++; $display("FAIL post_reset_unp_rst_n: got %b expected 1", unp_rst_n); end
  endtask

  task automatic test_full_load;
    int pops, mw, ae, gv, fl, ex;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (dbg_state !== 3'd1) begin failures++; $display("FAIL clear_state: got %0d expected 1", dbg_state); end
    checks++; if (unp_rst_n !== 1'b0) begin failures++; $display("FAIL clear_unp_rst_n: got %b expected 0", unp_rst_n); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy: got %b expected 1", busy); end
    tick();
    checks++; if (dbg_state !== 3'd2 || unp_rst_n !== 1'b1) begin failures++; $display("FAIL load_entry: got state %0d rst %b expected 2 1", dbg_state, unp_rst_n); end
    drive_load(3, -1, -1, pops, mw, ae, gv, fl, ex);
    checks++; if (ex !== 0) begin failures++; $display("FAIL full_budget: got expired=%0d expected 0", ex); end
    checks++; if (pops !== 3) begin failures++; $display("FAIL full_pops: got %0d expected 3", pops); end
    checks++; if (mw !== 10) begin failures++; $display("FAIL full_mem_writes: got %0d expected 10", mw); end
    checks++; if (ae !== 0) begin failures++; $display("FAIL full_addr_order: got %0d bad expected 0", ae); end
    checks++; if ({done, infer_en, error, busy} !== 4'b1100) begin failures++; $display("FAIL full_flags: got %b expected 1100", {done, infer_en, error, busy}); end
    checks++; if (weight_count !== 32'd10) begin failures++; $display("FAIL full_count: got %0d expected 10", weight_count); end
  endtask

  task automatic test_gating;
    int pops, mw, ae, gv, fl, ex;
    do_start();
    drive_load(5, -1, -1, pops, mw, ae, gv, fl, ex);
    checks++; if (pops !== 3) begin failures++; $display("FAIL gate_pops: got %0d expected 3", pops); end
    checks++; if (fl !== 2) begin failures++; $display("FAIL gate_fifo_left: got %0d expected 2", fl); end
    checks++; if (gv !== 0) begin failures++; $display("FAIL gate_unp_empty: got %0d open cycles expected 0", gv); end
    checks++; if (done !== 1'b1 || weight_count !== 32'd10) begin failures++; $display("FAIL gate_done: got done %b count %0d expected 1 10", done, weight_count); end
  endtask

  task automatic test_abort;
    int pops, mw, ae, gv, fl, ex;
    do_start();
    drive_load(3, 5, -1, pops, mw, ae, gv, fl, ex);
    checks++; if (ex !== 0) begin failures++; $display("FAIL abort_budget: got expired=%0d expected 0", ex); end
    checks++; if (mw !== 8 || weight_count !== 32'd8) begin failures++; $display("FAIL abort_count: got %0d/%0d expected 8", mw, weight_count); end
    checks++; if ({error, done, infer_en} !== 3'b100) begin failures++; $display("FAIL abort_flags: got %b expected 100", {error, done, infer_en}); end
    checks++; if (dbg_state !== 3'd5) begin failures++; $display("FAIL abort_state: got %0d expected 5", dbg_state); end
  endtask

  task automatic test_timeout;
    int n, pops, mw, ae, gv, fl, ex;
    fifo_empty = 1'b1;
    do_start();
    n = 0;
    while (error !== 1'b1 && n < 40) begin
      tick(); n++;
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL timeout_cycles: got %0d expected 16", n); end
    checks++; if ({error, busy, infer_en} !== 3'b100) begin failures++; $display("FAIL timeout_flags: got %b expected 100", {error, busy, infer_en}); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (dbg_state !== 3'd1 || unp_rst_n !== 1'b0) begin failures++; $display("FAIL restart_clear: got state %0d rst %b expected 1 0", dbg_state, unp_rst_n); end
    tick();
    checks++; if (unp_rst_n !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL restart_load: got rst %b err %b expected 1 0", unp_rst_n, error); end
    drive_load(3, -1, -1, pops, mw, ae, gv, fl, ex);
    checks++; if (done !== 1'b1 || weight_count !== 32'd10) begin failures++; $display("FAIL restart_done: got done %b count %0d expected 1 10", done, weight_count); end
  endtask

  task automatic test_addr_mismatch;
    int pops, mw, ae, gv, fl, ex;
    do_start();
    drive_load(3, -1, 6, pops, mw, ae, gv, fl, ex);
    checks++; if (mw !== 7) begin failures++; $display("FAIL mismatch_writes: got %0d expected 7", mw); end
    checks++; if (ae !== 0) begin failures++; $display("FAIL mismatch_prefix_order: got %0d expected 0", ae); end
    checks++; if ({error, done, dbg_state} !== {1'b1, 1'b0, 3'd5}) begin failures++; $display("FAIL mismatch_error: got err %b done %b state %0d expected 1 0 5", error, done, dbg_state); end
  endtask

  task automatic test_reset_mid_load;
    do_start();
    fifo_empty = 1'b0; unp_fifo_rd_en = 1'b1;
    tick();
    unp_fifo_rd_en = 1'b0; fifo_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      unp_wr_en = 1'b1; unp_wr_addr = 32'(i);
      tick();
    end
    unp_wr_en = 1'b0;
    checks++; if (weight_count !== 32'd4) begin failures++; $display("FAIL mid_count: got %0d expected 4", weight_count); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (dbg_state !== 3'd2 || weight_count !== 32'd4 || unp_rst_n !== 1'b1) begin failures++; $display("FAIL start_in_load: got state %0d count %0d rst %b expected 2 4 1", dbg_state, weight_count, unp_rst_n); end
    unp_wr_en = 1'b1; unp_wr_addr = 32'd4;
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_state !== 3'd0 || weight_count !== 32'd0) begin failures++; $display("FAIL mid_reset_state: got state %0d count %0d expected 0 0", dbg_state, weight_count); end
    checks++; if ({busy, done, error, infer_en, unp_rst_n} !== 5'b00000) begin failures++; $display("FAIL mid_reset_flags: got %b expected 00000", {busy, done, error, infer_en, unp_rst_n}); end
    checks++; if (mem_wr_en !== 1'b0 || unp_empty !== 1'b1) begin failures++; $display("FAIL mid_reset_gates: got wr %b empty %b expected 0 1", mem_wr_en, unp_empty); end
    tick();
    rst_n = 1'b1; unp_wr_en = 1'b0;
    tick(); tick();
    checks++; if (dbg_state !== 3'd0 || busy !== 1'b0 || unp_rst_n !== 1'b1) begin failures++; $display("FAIL after_reset_idle: got state %0d busy %b rst %b expected 0 0 1", dbg_state, busy, unp_rst_n); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gating();
    test_abort();
    test_timeout();
    test_addr_mismatch();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 Parameter NUM_WEIGHTS, default 76323: 16-bit weights to write per load.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: maximum consecutive idle cycles in LOAD without a write.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that requests a new weight load.
REQ-006 abort  input  1  level; cancels an in-progress load.
REQ-007 fifo_empty  input  1  empty flag of the 64-bit weight FIFO.
REQ-008 unp_fifo_rd_en  input  1  FIFO pop strobe from the 64-to-16 unpacker.
REQ-009 unp_wr_en  input  1  unpacker weight write strobe.
REQ-010 unp_wr_addr  input  32  unpacker weight write address.
REQ-011 unp_empty  output  1  gated empty flag driven to the unpacker.
REQ-012 unp_rst_n  output  1  registered active-low reset to the unpacker.
REQ-013 mem_wr_en  output  1  gated write enable to the weight memory.
REQ-014 weight_count  output  32  weights committed in the current load.
REQ-015 busy / done / error  output  1 each  status flags.
REQ-016 infer_en  output  1  weights valid; inference may start.

Function
REQ-017 States SHALL be IDLE, CLEAR, LOAD, FLUSH, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR: start=1 -> CLEAR; otherwise hold.
REQ-019 CLEAR SHALL last exactly one cycle with unp_rst_n=0, then go to LOAD; unp_rst_n=1 in all other states.
REQ-020 On entering CLEAR, weight_count, the word counter, the timeout counter and the abort flag SHALL clear to 0.
REQ-021 Word counter SHALL increment on unp_fifo_rd_en & ~unp_empty; WORDS_NEEDED = ceil(NUM_WEIGHTS/4).
REQ-022 unp_empty SHALL be fifo_empty OR (state != LOAD) OR (word counter >= WORDS_NEEDED), combinational.
REQ-023 mem_wr_en SHALL be unp_wr_en AND state in {LOAD, FLUSH} AND weight_count < NUM_WEIGHTS, combinational; padding writes beyond NUM_WEIGHTS are suppressed and not counted.
REQ-024 weight_count SHALL increment by 1 per cycle with mem_wr_en=1.
REQ-025 A write with mem_wr_en=1 and unp_wr_addr != weight_count SHALL move LOAD/FLUSH to ERROR on the next edge.
REQ-026 LOAD -> FLUSH when a write brings weight_count to NUM_WEIGHTS, or when abort=1 (abort flag set).
REQ-027 Simultaneous abort and final write: completion wins; abort flag stays 0.
REQ-028 LOAD -> ERROR when the timeout counter reaches TIMEOUT_CYCLES; counter resets on every unp_wr_en, increments otherwise.
REQ-029 FLUSH: when unp_wr_en=0 -> DONE if abort flag=0 and weight_count=NUM_WEIGHTS, else ERROR.
REQ-030 start in CLEAR/LOAD/FLUSH SHALL be ignored; abort outside LOAD SHALL be ignored.
REQ-031 busy=1 in CLEAR/LOAD/FLUSH; done=1 and infer_en=1 only in DONE; error=1 only in ERROR; all registered decodes of state.

Reset
REQ-032 rst_n=0 at any time, including mid-load, SHALL force IDLE immediately: counters 0, busy/done/error/infer_en=0, unp_rst_n=0 while rst_n=0, unp_empty=1, mem_wr_en=0.
REQ-033 After release, the block SHALL remain in IDLE until start; a new load always passes through CLEAR.

Verification (NUM_WEIGHTS=10, TIMEOUT_CYCLES=16)
REQ-034 Full load: start, FIFO holds 3 words, unpacker produces 12 writes at addr 0..11 -> mem_wr_en for exactly 10 writes (addr 0..9), 3 pops, done=1, infer_en=1, weight_count=10.
REQ-035 Gating: FIFO holds 5 words -> unp_empty=1 after the 3rd pop; words 4-5 remain unpopped.
REQ-036 Abort: abort after 5 writes -> FLUSH until the current group ends, then ERROR, error=1, infer_en=0.
REQ-037 Timeout: FIFO empty for 16 cycles in LOAD -> error=1; a following start -> CLEAR (unp_rst_n=0 for one cycle), then a clean load reaches done.
REQ-038 Address mismatch: inject unp_wr_addr=7 while weight_count=6 -> ERROR next cycle.
REQ-039 Reset mid-load after 4 writes -> IDLE, weight_count=0, all flags 0; start pulse during LOAD produces no state change.
